// File: rtl/seq_player.sv
// Sequence playback engine: fetches a tag from the tag RAM, then streams ROM
// words one per step tick until a word carrying a non-zero end marker is seen.
module seq_player #(
  parameter int ADDR_W = 10,
  parameter int SEQ_W  = 6,
  parameter int RD_LAT = 1
) (
  input  logic              CLK_50,
  input  logic              reset,
  input  logic [SEQ_W-1:0]  seq_num,
  input  logic              start,
  input  logic              stop,
  input  logic              step,
  output logic [SEQ_W-1:0]  ram_rdaddress,
  input  logic [31:0]       ram_q,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_q,
  output logic [29:0]       sample,
  output logic              sample_valid,
  output logic              busy,
  output logic              done,
  output logic              err_invalid
);

  typedef enum logic [1:0] {IDLE, TAG_WAIT, ROM_WAIT, HOLD} state_t;

  localparam logic [1:0]        LAT      = 2'(RD_LAT);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t     state;
  logic [1:0] cnt;
  logic [1:0] marker;

  // Tag bits between the valid flag and the start address carry nothing.
  logic unused_tag_bits;
  assign unused_tag_bits = ^ram_q[30:ADDR_W];

  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      marker        <= '0;
      ram_rdaddress <= '0;
      rom_addr      <= '0;
      sample        <= '0;
      sample_valid  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_invalid   <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      done         <= 1'b0;
      err_invalid  <= 1'b0;
      if (stop && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !stop) begin
              ram_rdaddress <= seq_num;
              cnt           <= LAT;
              busy          <= 1'b1;
              state         <= TAG_WAIT;
            end
          end
          TAG_WAIT: begin
            cnt <= cnt - 2'd1;
            if (cnt == 2'd1) begin
              if (ram_q[31]) begin
                rom_addr <= ram_q[ADDR_W-1:0];
                cnt      <= LAT;
                state    <= ROM_WAIT;
              end else begin
                err_invalid <= 1'b1;
                busy        <= 1'b0;
                state       <= IDLE;
              end
            end
          end
          ROM_WAIT: begin
            cnt <= cnt - 2'd1;
            if (cnt == 2'd1) begin
              sample       <= rom_q[31:2];
              marker       <= rom_q[1:0];
              sample_valid <= 1'b1;
              state        <= HOLD;
            end
          end
          HOLD: begin
            // A step coinciding with the sample_valid pulse is deliberately lost.
            if (step && !sample_valid) begin
              if (marker != 2'b00) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end else if (rom_addr != ADDR_MAX) begin
                rom_addr <= rom_addr + ADDR_W'(1);
                cnt      <= LAT;
                state    <= ROM_WAIT;
              end else begin
                done        <= 1'b1;
                err_invalid <= 1'b1;
                busy        <= 1'b0;
                state       <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_player.sv
// Scoreboard bench for seq_player: one instance with RD_LAT=1, one with RD_LAT=3,
// sharing tag/ROM contents; stimulus pushes expected events, a monitor pops them.
module tb_seq_player;

  typedef struct {
    int          cyc;
    logic [29:0] smp;
    logic        sv;
    logic        dn;
    logic        er;
  } exp_t;

  localparam logic [29:0] PA = 30'h0AAAA001, PB = 30'h0BBBB002, PC = 30'h0CCCC003;
  localparam logic [29:0] PD = 30'h0DDDD004, PE = 30'h0EEEE005;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  logic        rst[2];
  logic [5:0]  seqn[2];
  logic        start[2], stop[2], step[2];
  logic [5:0]  rda[2];
  logic [31:0] ram_q[2];
  logic [9:0]  ra[2];
  logic [31:0] rom_q[2];
  logic [29:0] smp[2];
  logic        sv[2], bsy[2], dn[2], er[2];

  logic [31:0] tag_mem[64];
  logic [31:0] rom_mem[1024];
  logic [31:0] rq_a, rq_b, rm_a, rm_b;

  exp_t sbq[2][$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_player #(.ADDR_W(10), .SEQ_W(6), .RD_LAT(1)) dut1 (
    .CLK_50(clk), .reset(rst[0]), .seq_num(seqn[0]), .start(start[0]), .stop(stop[0]),
    .step(step[0]), .ram_rdaddress(rda[0]), .ram_q(ram_q[0]), .rom_addr(ra[0]),
    .rom_q(rom_q[0]), .sample(smp[0]), .sample_valid(sv[0]), .busy(bsy[0]),
    .done(dn[0]), .err_invalid(er[0]));

  seq_player #(.ADDR_W(10), .SEQ_W(6), .RD_LAT(3)) dut3 (
    .CLK_50(clk), .reset(rst[1]), .seq_num(seqn[1]), .start(start[1]), .stop(stop[1]),
    .step(step[1]), .ram_rdaddress(rda[1]), .ram_q(ram_q[1]), .rom_addr(ra[1]),
    .rom_q(rom_q[1]), .sample(smp[1]), .sample_valid(sv[1]), .busy(bsy[1]),
    .done(dn[1]), .err_invalid(er[1]));

  // RD_LAT=1 memories answer the registered address directly; RD_LAT=3 adds two stages.
  assign ram_q[0] = tag_mem[rda[0]];
  assign rom_q[0] = rom_mem[ra[0]];
  always @(posedge clk) begin
    rq_a <= tag_mem[rda[1]];
    rq_b <= rq_a;
    rm_a <= rom_mem[ra[1]];
    rm_b <= rm_a;
  end
  assign ram_q[1] = rq_b;
  assign rom_q[1] = rm_b;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (sv[d] || dn[d] || er[d]) begin
        tests++;
        if (sbq[d].size() == 0) begin
          fails++;
          $display("FAIL unexpected_event dut%0d cyc %0d got sv=%b done=%b err=%b, required none",
                   d, cyc, sv[d], dn[d], er[d]);
        end else begin
          mon_e = sbq[d].pop_front();
          if ({sv[d], dn[d], er[d]} != {mon_e.sv, mon_e.dn, mon_e.er} || cyc != mon_e.cyc ||
              (mon_e.sv && smp[d] != mon_e.smp)) begin
            fails++;
            $display("FAIL event dut%0d got cyc %0d sv=%b done=%b err=%b sample=%h, required cyc %0d sv=%b done=%b err=%b sample=%h",
                     d, cyc, sv[d], dn[d], er[d], smp[d], mon_e.cyc, mon_e.sv, mon_e.dn, mon_e.er, mon_e.smp);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s got %h required %h", name, act, req);
    end
  endtask

  task automatic push(input int d, input int c, input logic [29:0] p,
                      input logic s, input logic n, input logic e);
    exp_t x;
    x.cyc = c; x.smp = p; x.sv = s; x.dn = n; x.er = e;
    sbq[d].push_back(x);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Tasks below are entered at a negedge and return at the following negedge.
  task automatic do_start(input int d, input logic [5:0] s, output int at);
    at = cyc; start[d] = 1'b1; seqn[d] = s;
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  task automatic do_step(input int d, output int at);
    at = cyc; step[d] = 1'b1;
    @(negedge clk);
    step[d] = 1'b0;
  endtask

  task automatic chk_zero(input int d, input string name);
    chk(name, {14'd0, bsy[d], sv[d], dn[d], er[d], smp[d], ra[d], rda[d]}, 64'd0);
  endtask

  task automatic play5(input int d);
    int s, h, l;
    l = (d == 0) ? 1 : 3;
    do_start(d, 6'd5, s);
    push(d, s + 2*l + 1, PA, 1, 0, 0);
    chk("play_rdaddr", 64'(rda[d]), 64'd5);
    chk("play_busy", 64'(bsy[d]), 64'd1);
    wait_to(s + 2*l + 2);
    do_step(d, h);
    push(d, h + 1 + l, PB, 1, 0, 0);
    wait_to(h + l + 2);
    do_step(d, h);
    push(d, h + 1 + l, PC, 1, 0, 0);
    wait_to(h + l + 2);
    do_step(d, h);
    push(d, h + 1, '0, 0, 1, 0);
    chk("play_end_busy", 64'(bsy[d]), 64'd0);
    chk("play_end_addr", 64'(ra[d]), 64'h102);
  endtask

  initial begin
    int s, h;
    for (int i = 0; i < 64; i++) tag_mem[i] = 32'h0;
    for (int i = 0; i < 1024; i++) rom_mem[i] = 32'h0;
    tag_mem[5] = 32'h8000_0100;
    tag_mem[7] = 32'h0000_0200;
    tag_mem[9] = 32'h8000_03FF;
    tag_mem[2] = 32'h8000_0200;
    rom_mem[10'h100] = {PA, 2'b00};
    rom_mem[10'h101] = {PB, 2'b00};
    rom_mem[10'h102] = {PC, 2'b01};
    rom_mem[10'h3FF] = {PD, 2'b00};
    rom_mem[10'h200] = {PE, 2'b10};
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; seqn[d] = '0; start[d] = 1'b0; stop[d] = 1'b0; step[d] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    chk_zero(0, "reset_dut1");
    chk_zero(1, "reset_dut3");
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);

    // Normal three-word sequence
    play5(0);
    @(negedge clk);

    // Tag with valid bit clear
    do_start(0, 6'd7, s);
    push(0, s + 2, '0, 0, 0, 1);
    wait_to(s + 3);
    chk("invalid_busy", 64'(bsy[0]), 64'd0);

    // Last ROM address with marker 00: no wrap
    do_start(0, 6'd9, s);
    push(0, s + 3, PD, 1, 0, 0);
    wait_to(s + 4);
    do_step(0, h);
    push(0, h + 1, '0, 0, 1, 1);
    chk("top_addr_hold", 64'(ra[0]), 64'h3FF);
    chk("top_busy", 64'(bsy[0]), 64'd0);

    // Stop during ROM_WAIT, then a clean replay
    do_start(0, 6'd2, s);
    wait_to(s + 2);
    stop[0] = 1'b1;
    @(negedge clk);
    stop[0] = 1'b0;
    chk("stop_busy", 64'(bsy[0]), 64'd0);
    chk("stop_addr", 64'(ra[0]), 64'h200);
    repeat (4) @(negedge clk);
    play5(0);
    @(negedge clk);

    // start in HOLD, step on the sample_valid cycle and in ROM_WAIT are all ignored
    do_start(0, 6'd5, s);
    push(0, s + 3, PA, 1, 0, 0);
    wait_to(s + 3);
    step[0] = 1'b1;
    @(negedge clk);
    step[0] = 1'b0; start[0] = 1'b1; seqn[0] = 6'd7;
    @(negedge clk);
    start[0] = 1'b0;
    chk("ignored_start_rdaddr", 64'(rda[0]), 64'd5);
    chk("ignored_start_busy", 64'(bsy[0]), 64'd1);
    do_step(0, h);
    push(0, h + 2, PB, 1, 0, 0);
    do_step(0, s);
    wait_to(h + 3);
    do_step(0, h);
    push(0, h + 2, PC, 1, 0, 0);
    wait_to(h + 3);
    do_step(0, h);
    push(0, h + 1, '0, 0, 1, 0);
    chk("ignored_end_busy", 64'(bsy[0]), 64'd0);

    // Asynchronous reset while holding a sample
    do_start(0, 6'd5, s);
    push(0, s + 3, PA, 1, 0, 0);
    wait_to(s + 4);
    chk("pre_reset_busy", 64'(bsy[0]), 64'd1);
    rst[0] = 1'b1;
    #1;
    chk_zero(0, "async_reset");
    @(negedge clk);
    rst[0] = 1'b0;

    // Same sequence with RD_LAT=3
    play5(1);

    repeat (6) @(negedge clk);
    chk("sb_empty_dut1", 64'(sbq[0].size()), 64'd0);
    chk("sb_empty_dut3", 64'(sbq[1].size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
